bram_seq: RTL and testbench
===========================

Name: bram_seq

Overview:
Initiator for the 256 x 8 single-port BRAM. On command, it either fills an address range with a deterministic pattern (FILL) or reads the range back and checks it against the same pattern (CHECK). It drives the BRAM address, write-data and readWrite lines and consumes the BRAM read data, which has one cycle of registered latency. It sits between the board switches/buttons and the BRAM, and reports a pass/fail summary to the LEDs/display.

Parameters:
ADDR_W, 8, BRAM address width (depth = 2**ADDR_W)
DATA_W, 8, BRAM data width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle command pulse, sampled only in IDLE
mode  in  1  0 = FILL, 1 = CHECK; sampled with start
start_addr  in  ADDR_W  first address of range
end_addr  in  ADDR_W  last address of range (inclusive)
seed  in  DATA_W  pattern base value
mem_addr  out  ADDR_W  BRAM address
mem_wdata  out  DATA_W  BRAM write data
mem_rw  out  1  BRAM readWrite: 1 = write, 0 = read
mem_rdata  in  DATA_W  BRAM registered read data
busy  out  1  high from the cycle after start is accepted until DONE exits
done  out  1  one-cycle pulse at end of operation
err_cnt  out  ADDR_W+1  mismatch count of last CHECK (0..256)
first_err_addr  out  ADDR_W  address of first mismatch in last CHECK
err_flag  out  1  set if last CHECK had at least one mismatch

Behaviour:
- Reset (async, rst_n=0): state=IDLE; mem_addr=0, mem_wdata=0, mem_rw=0, busy=0, done=0, err_cnt=0, first_err_addr=0, err_flag=0. Reset mid-operation aborts immediately; BRAM contents are left partially written.
- Range length N = ((end_addr - start_addr) mod 2**ADDR_W) + 1. end_addr < start_addr wraps through the top address to 0. start_addr == end_addr gives N=1. Full range gives N=256.
- Pattern: expected(a) = (seed + ((a - start_addr) mod 2**ADDR_W)) mod 2**DATA_W.
- States: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE: mem_rw=0. start=1 latches mode, range and seed. FILL -> WRITE; CHECK -> READ, which clears err_cnt, err_flag and first_err_addr.
- WRITE: one address per cycle, mem_rw=1, mem_addr/mem_wdata registered outputs. After the end_addr write, go to DONE. FILL occupies N cycles.
- READ: one address per cycle, mem_rw=0. The expected value and a valid bit are delayed one cycle to align with mem_rdata. After issuing end_addr, go to DRAIN for one cycle to compare the last datum, then go to DONE.
- Compare rule: on each valid cycle with mem_rdata != expected, err_cnt increments and err_flag is set. first_err_addr captures only the first mismatch.
- DONE: done=1 for exactly one cycle, busy=1, mem_rw=0. Next state is IDLE.
- Latency (start sampled at edge 0): FILL gives done high in cycle N+1. CHECK gives done high in cycle N+2.
- start outside IDLE is ignored. Inputs changing while busy have no effect.
- Result outputs hold until the next CHECK starts or reset. FILL does not alter them.

Optional Feature:
BRAM_SEQ_ERR_STOP_EN
- Defined: on the first CHECK mismatch, the block stops issuing reads, moves to DONE on the next cycle, and leaves err_cnt=1. Any read already in flight is discarded.
- Undefined: the full range is always scanned and every mismatch is counted.

Decomposition:
- Shared package bram_pkg holds:
  - ADDR_W/DATA_W defaults
  - state typedef (IDLE/WRITE/READ/DRAIN/DONE)
  - MODE_FILL/MODE_CHECK constants
- One natural sub-module: bram_seq_addr_gen. It holds the wrapping address counter, the offset counter, pattern generation and the last-address flag. It is shared by the WRITE and READ paths.

Test Plan:
- FILL start=0x10 end=0x1F seed=0xA0, then CHECK same -> model holds 0xA0..0xAF at 0x10..0x1F; done at cycle 17 (FILL) / 18 (CHECK); err_cnt=0, err_flag=0.
- FILL 0x00..0xFF seed=0x00, then CHECK -> every bram[a]=a; err_cnt=0; FILL busy for exactly 257 cycles (256 WRITE + DONE).
- Wrap: FILL start=0xFE end=0x01 seed=0x55 -> writes FE=55, FF=56, 00=57, 01=58 only; neighbours 0xFD/0x02 untouched.
- After FILL 0x20..0x2F seed 0, bench corrupts 0x24 and 0x2A, then CHECK -> err_cnt=2, first_err_addr=0x24, err_flag=1; with BRAM_SEQ_ERR_STOP_EN -> err_cnt=1, done earlier.
- start pulsed while busy, and mode/range toggled mid-FILL -> no change to the sequence or to the done timing.
- rst_n low at cycle 5 of a FILL -> all outputs at reset values asynchronously; a subsequent start runs normally.

Source files
------------

// File: rtl/bram_pkg.sv
// Shared definitions for the BRAM fill/check sequencer.
// Optional build macro used by the sequencer: BRAM_SEQ_ERR_STOP_EN
// (stop a CHECK at its first mismatch instead of scanning the full range).
package bram_pkg;

  // Default geometry of the 256 x 8 BRAM.
  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  // Sequencer state encoding, kept as plain constants so it reads the same in older flows.
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_WRITE = 3'd1;
  localparam state_t ST_READ  = 3'd2;
  localparam state_t ST_DRAIN = 3'd3;
  localparam state_t ST_DONE  = 3'd4;

  // Command mode values sampled with start.
  localparam logic MODE_FILL  = 1'b0;
  localparam logic MODE_CHECK = 1'b1;

endpackage

// File: rtl/bram_seq_addr_gen.sv
// Address / pattern generator shared by the WRITE and READ paths.
// Holds the wrapping address counter, the offset from start_addr, the running
// pattern value (seed + offset) and flags the last address of the range.
// Optional build macro of the enclosing design: BRAM_SEQ_ERR_STOP_EN (not used here).
module bram_seq_addr_gen #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              advance,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  input  logic [DATA_W-1:0] seed,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] pat,
  output logic              last
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] DATA_ONE = {{(DATA_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0] addr_q,   addr_d;
  logic [ADDR_W-1:0] off_q,    off_d;
  logic [ADDR_W-1:0] len_m1_q, len_m1_d;
  logic [DATA_W-1:0] pat_q,    pat_d;

  // Next-state: load a new range on command, otherwise step one address when asked.
  always_comb begin
    addr_d   = addr_q;
    off_d    = off_q;
    len_m1_d = len_m1_q;
    pat_d    = pat_q;
    if (load) begin
      addr_d   = start_addr;
      off_d    = {ADDR_W{1'b0}};
      // Modular difference: a range with end below start wraps through the top address.
      len_m1_d = end_addr - start_addr;
      pat_d    = seed;
    end else if (advance) begin
      addr_d = addr_q + ADDR_ONE;
      off_d  = off_q + ADDR_ONE;
      pat_d  = pat_q + DATA_ONE;
    end else begin
      addr_d = addr_q;
    end
  end

  // Counter registers; these drive the BRAM address and write data directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= {ADDR_W{1'b0}};
      off_q    <= {ADDR_W{1'b0}};
      len_m1_q <= {ADDR_W{1'b0}};
      pat_q    <= {DATA_W{1'b0}};
    end else begin
      addr_q   <= addr_d;
      off_q    <= off_d;
      len_m1_q <= len_m1_d;
      pat_q    <= pat_d;
    end
  end

  assign addr = addr_q;
  assign pat  = pat_q;
  // Offset reaching N-1 marks the end address, which also covers the full 256-entry range.
  assign last = (off_q == len_m1_q);

endmodule

// File: rtl/bram_seq.sv
// BRAM fill/check sequencer: FILL writes seed+offset over an address range,
// CHECK reads the range back (one-cycle registered read latency) and counts
// mismatches, recording the first failing address.
// Optional build macro: BRAM_SEQ_ERR_STOP_EN -- when defined, a CHECK ends at
// its first mismatch with err_cnt=1; otherwise the whole range is scanned.
module bram_seq
  import bram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  input  logic [DATA_W-1:0] seed,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rw,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   err_cnt,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic              err_flag
);

  localparam logic [ADDR_W:0] ERR_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t state_q, state_d;
  logic   rw_q, rw_d;
  logic   busy_q, busy_d;
  logic   done_q, done_d;
  // Read-compare pipeline: expected value, its address and a valid bit, one cycle behind issue.
  logic              vld_q, vld_d;
  logic [DATA_W-1:0] exp_q, exp_d;
  logic [ADDR_W-1:0] cmp_addr_q, cmp_addr_d;
  // Result registers held until the next CHECK starts.
  logic [ADDR_W:0]   err_cnt_q, err_cnt_d;
  logic [ADDR_W-1:0] first_err_q, first_err_d;
  logic              err_flag_q, err_flag_d;

  logic              load_s;
  logic              adv_s;
  logic              last_s;
  logic              mismatch_s;
  logic              stop_s;
  logic              check_start_s;
  logic [ADDR_W-1:0] gen_addr_s;
  logic [DATA_W-1:0] gen_pat_s;

  bram_seq_addr_gen #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_addr_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load_s),
    .advance    (adv_s),
    .start_addr (start_addr),
    .end_addr   (end_addr),
    .seed       (seed),
    .addr       (gen_addr_s),
    .pat        (gen_pat_s),
    .last       (last_s)
  );

  assign mismatch_s    = vld_q && (mem_rdata != exp_q);
  assign check_start_s = (state_q == ST_IDLE) && start && (mode == MODE_CHECK);
`ifdef BRAM_SEQ_ERR_STOP_EN
  assign stop_s = mismatch_s;
`else
  assign stop_s = 1'b0;
`endif

  // State transitions and address-generator control.
  always_comb begin
    state_d = state_q;
    load_s  = 1'b0;
    adv_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          load_s  = 1'b1;
          state_d = (mode == MODE_CHECK) ? ST_READ : ST_WRITE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (last_s) begin
          state_d = ST_DONE;
        end else begin
          adv_s = 1'b1;
        end
      end
      ST_READ: begin
        if (stop_s) begin
          state_d = ST_DONE;
        end else if (last_s) begin
          state_d = ST_DRAIN;
        end else begin
          adv_s = 1'b1;
        end
      end
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Registered control outputs and the compare pipeline, derived from the next state.
  always_comb begin
    rw_d       = (state_d == ST_WRITE);
    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_d == ST_DONE);
    // A read issued this cycle is compared next cycle; an early stop discards it.
    vld_d      = (state_q == ST_READ) && !stop_s;
    exp_d      = gen_pat_s;
    cmp_addr_d = gen_addr_s;
  end

  // Result accumulation: cleared at CHECK start, updated on every valid mismatch.
  always_comb begin
    err_cnt_d   = err_cnt_q;
    first_err_d = first_err_q;
    err_flag_d  = err_flag_q;
    if (check_start_s) begin
      err_cnt_d   = {(ADDR_W+1){1'b0}};
      first_err_d = {ADDR_W{1'b0}};
      err_flag_d  = 1'b0;
    end else if (mismatch_s) begin
      err_cnt_d  = err_cnt_q + ERR_ONE;
      err_flag_d = 1'b1;
      if (!err_flag_q) begin
        first_err_d = cmp_addr_q;
      end else begin
        first_err_d = first_err_q;
      end
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // Sequencer, pipeline and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rw_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      vld_q       <= 1'b0;
      exp_q       <= {DATA_W{1'b0}};
      cmp_addr_q  <= {ADDR_W{1'b0}};
      err_cnt_q   <= {(ADDR_W+1){1'b0}};
      first_err_q <= {ADDR_W{1'b0}};
      err_flag_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rw_q        <= rw_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      vld_q       <= vld_d;
      exp_q       <= exp_d;
      cmp_addr_q  <= cmp_addr_d;
      err_cnt_q   <= err_cnt_d;
      first_err_q <= first_err_d;
      err_flag_q  <= err_flag_d;
    end
  end

  assign mem_addr       = gen_addr_s;
  assign mem_wdata      = gen_pat_s;
  assign mem_rw         = rw_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err_cnt        = err_cnt_q;
  assign first_err_addr = first_err_q;
  assign err_flag       = err_flag_q;

endmodule

// File: tb/tb_bram_seq.sv
// Testbench for bram_seq: behavioural BRAM, reference memory model, scoreboard
// of expected completions checked by an independent monitor.
// Honours BRAM_SEQ_ERR_STOP_EN for the expected CHECK results.
module tb_bram_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       mode = 1'b0;
  logic [7:0] start_addr = 8'd0;
  logic [7:0] end_addr = 8'd0;
  logic [7:0] seed = 8'd0;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_rw;
  logic [7:0] mem_rdata = 8'd0;
  logic       busy;
  logic       done;
  logic [8:0] err_cnt;
  logic [7:0] first_err_addr;
  logic       err_flag;

  always #5 clk = ~clk;

  bram_seq #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .start_addr(start_addr), .end_addr(end_addr), .seed(seed),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rw(mem_rw),
    .mem_rdata(mem_rdata), .busy(busy), .done(done), .err_cnt(err_cnt),
    .first_err_addr(first_err_addr), .err_flag(err_flag)
  );

  // Behavioural BRAM with registered read; bench corruption goes through the same port.
  logic [7:0] bram [256];
  logic       cor_en = 1'b0;
  logic [7:0] cor_addr = 8'd0;
  logic [7:0] cor_val = 8'd0;
  always @(posedge clk) begin
    if (cor_en) bram[cor_addr] <= cor_val;
    else if (mem_rw) bram[mem_addr] <= mem_wdata;
    mem_rdata <= bram[mem_addr];
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state.
  logic [7:0] ref_mem [256];
  int         m_cnt = 0;
  int         m_first = 0;
  bit         m_flag = 1'b0;

  typedef struct {
    int unsigned done_cyc;
    int          lat;
    int          cnt;
    int          first;
    bit          flag;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input bit ok, input string nm, input longint act, input longint expv);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever done pulses.
  int busy_cnt = 0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy_cnt = 0;
      end else begin
        if (busy) busy_cnt++;
        if (done) begin
          chk(sb.size() != 0, "done_expected", sb.size(), 1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            chk(cyc == e.done_cyc, "done_cycle", cyc, e.done_cyc);
            chk(busy_cnt == e.lat, "busy_cycles", busy_cnt, e.lat);
            chk(err_cnt == e.cnt, "err_cnt", err_cnt, e.cnt);
            chk(first_err_addr == e.first, "first_err_addr", first_err_addr, e.first);
            chk(err_flag == e.flag, "err_flag", err_flag, e.flag);
          end
          busy_cnt = 0;
        end
      end
    end
  end

  task automatic mem_cmp(input string nm);
    int bad = 0;
    for (int a = 0; a < 256; a++) if (bram[a] !== ref_mem[a]) bad++;
    chk(bad == 0, nm, bad, 0);
  endtask

  task automatic wait_done();
    bit ok = 1'b0;
    for (int i = 0; i < 600 && !ok; i++) begin
      @(negedge clk);
      if (done) ok = 1'b1;
    end
    chk(ok, "done_timeout", ok, 1);
    @(negedge clk);
  endtask

  task automatic corrupt(input int a, input logic [7:0] v);
    cor_en = 1'b1; cor_addr = a[7:0]; cor_val = v;
    ref_mem[a] = v;
    @(negedge clk);
    cor_en = 1'b0;
  endtask

  // Issue one command from IDLE (called at a negedge), record expectations, run to completion.
  task automatic run_op(input bit m, input int s, input int e, input int sd, input bit disturb);
    exp_t x;
    int   n = ((e - s) & 255) + 1;
    int   first_j = -1;
    int   a;
    int   pv;
    x.lat = m ? n + 2 : n + 1;
    if (!m) begin
      for (int j = 0; j < n; j++) ref_mem[(s + j) & 255] = 8'((sd + j) & 255);
    end else begin
      m_cnt = 0; m_first = 0; m_flag = 1'b0;
      for (int j = 0; j < n; j++) begin
        a  = (s + j) & 255;
        pv = (sd + j) & 255;
        if (int'(ref_mem[a]) != pv) begin
          if (!m_flag) begin m_first = a; first_j = j; end
          m_flag = 1'b1;
          m_cnt++;
        end
      end
`ifdef BRAM_SEQ_ERR_STOP_EN
      if (m_flag) begin m_cnt = 1; x.lat = first_j + 3; end
`endif
    end
    x.done_cyc = cyc + x.lat;
    x.cnt = m_cnt; x.first = m_first; x.flag = m_flag;
    sb.push_back(x);
    mode = m; start_addr = s[7:0]; end_addr = e[7:0]; seed = sd[7:0]; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (disturb) begin
      for (int k = 0; k < 4; k++) begin
        start = 1'b1; mode = ~mode;
        start_addr = 8'($urandom); end_addr = 8'($urandom); seed = 8'($urandom);
        @(negedge clk);
      end
      start = 1'b0;
    end
    wait_done();
    mem_cmp(m ? "mem_after_check" : "mem_after_fill");
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk(mem_addr == 8'd0, {tag, "_mem_addr"}, mem_addr, 0);
    chk(mem_wdata == 8'd0, {tag, "_mem_wdata"}, mem_wdata, 0);
    chk(mem_rw == 1'b0, {tag, "_mem_rw"}, mem_rw, 0);
    chk(busy == 1'b0, {tag, "_busy"}, busy, 0);
    chk(done == 1'b0, {tag, "_done"}, done, 0);
    chk(err_cnt == 9'd0, {tag, "_err_cnt"}, err_cnt, 0);
    chk(first_err_addr == 8'd0, {tag, "_first_err"}, first_err_addr, 0);
    chk(err_flag == 1'b0, {tag, "_err_flag"}, err_flag, 0);
  endtask

  initial begin
    int s, e, sd, a;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Full range fill then check: bram[a] = a.
    run_op(1'b0, 8'h00, 8'hFF, 8'h00, 1'b0);
    run_op(1'b1, 8'h00, 8'hFF, 8'h00, 1'b0);
    // Directed 16-entry range.
    run_op(1'b0, 8'h10, 8'h1F, 8'hA0, 1'b0);
    run_op(1'b1, 8'h10, 8'h1F, 8'hA0, 1'b0);
    // Wrapping range and single-address range.
    run_op(1'b0, 8'hFE, 8'h01, 8'h55, 1'b0);
    run_op(1'b1, 8'hFE, 8'h01, 8'h55, 1'b0);
    run_op(1'b0, 8'h80, 8'h80, 8'h3C, 1'b0);
    run_op(1'b1, 8'h80, 8'h80, 8'h3C, 1'b0);
    // Start/mode/range disturbance while busy.
    run_op(1'b0, 8'h30, 8'h4F, 8'h21, 1'b1);
    run_op(1'b1, 8'h30, 8'h4F, 8'h21, 1'b1);
    // Corrupted check.
    run_op(1'b0, 8'h20, 8'h2F, 8'h00, 1'b0);
    corrupt(8'h24, 8'hFF);
    corrupt(8'h2A, 8'h00);
    run_op(1'b1, 8'h20, 8'h2F, 8'h00, 1'b0);
    // FILL leaves results untouched.
    run_op(1'b0, 8'h90, 8'h97, 8'h07, 1'b0);

    // Asynchronous reset in cycle 5 of a FILL.
    mode = 1'b0; start_addr = 8'h40; end_addr = 8'h7F; seed = 8'h11; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    for (int j = 0; j < 4; j++) ref_mem[8'h40 + j] = 8'(8'h11 + j);
    m_cnt = 0; m_first = 0; m_flag = 1'b0;
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mem_cmp("mem_after_reset");
    run_op(1'b1, 8'h40, 8'h43, 8'h11, 1'b0);
    run_op(1'b0, 8'h40, 8'h7F, 8'h11, 1'b0);

    // Randomised commands with occasional corruption.
    for (int i = 0; i < 12; i++) begin
      s  = int'($urandom_range(0, 255));
      e  = int'($urandom_range(0, 255));
      sd = int'($urandom_range(0, 255));
      run_op(1'b0, s, e, sd, 1'b0);
      if ($urandom_range(0, 1) == 1) begin
        a = (s + int'($urandom_range(0, ((e - s) & 255)))) & 255;
        corrupt(a, ref_mem[a] ^ 8'($urandom_range(1, 255)));
      end
      if ($urandom_range(0, 3) == 0) sd = int'($urandom_range(0, 255));
      run_op(1'b1, s, e, sd, ($urandom_range(0, 1) == 1) && (((e - s) & 255) >= 8));
    end

    repeat (3) @(negedge clk);
    chk(sb.size() == 0, "scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
